fib_monitor: RTL and testbench
==============================

Name: fib_monitor

Overview:
- Downstream stage of the Fibonacci sequencer. Samples each newly loaded term on the sequencer's 8-bit output.
- Checks every term against the Fibonacci recurrence (modulo 2^WIDTH) and keeps term, error and wrap statistics.
- Buffers accepted terms in a small FIFO and hands them to a consumer over a valid/ready interface.
- The sequencer's sum-load strobe is wired to fib_valid at the top level.

Parameters:
WIDTH, 8, data width of fib_in and out_data
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_W, 8, width of term_count and err_count

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
fib_in  input  WIDTH  term from sequencer output
fib_valid  input  1  fib_in holds a newly loaded term this cycle
clear  input  1  synchronous clear, same effect as reset
out_data  output  WIDTH  FIFO head term
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data this cycle
term_count  output  CNT_W  terms sampled, saturating
err_count  output  CNT_W  recurrence mismatches, saturating
err  output  1  sticky: at least one mismatch
wrapped  output  1  sticky: a term's true sum exceeded 2^WIDTH-1
dropped  output  1  sticky: a term was lost to a full FIFO

Behaviour:
- Reset (reset=0, asynchronous) and clear=1 (synchronous):
  - All outputs go to 0: out_data, out_valid, counts, err, wrapped, dropped.
  - FIFO is emptied and history registers p1/p2 are zeroed.
  - clear has priority over fib_valid and out_ready in the same cycle.
- Sampling:
  - On each clock with fib_valid=1, fib_in is a sample.
  - term_count increments and saturates at 2^CNT_W-1.
  - History shifts: p2<=p1, p1<=fib_in.
  - Sampling continues regardless of FIFO state.
- Recurrence check:
  - Applies only once term_count>=2 before the sample.
  - expected = (p1+p2) mod 2^WIDTH.
  - If fib_in!=expected: err<=1 and err_count increments, saturating. Visible the cycle after the sample.
  - The first two samples are never checked.
  - If the (WIDTH+1)-bit sum p1+p2 has its carry bit set, wrapped<=1 (checked samples only). A wrapped term that matches expected is not an error.
- FIFO:
  - Show-ahead: out_data is always the head entry; out_valid = not empty.
  - Pop occurs when out_valid & out_ready.
  - Push occurs when fib_valid and (not full, or a pop happens in the same cycle).
  - Push and pop in the same cycle leave occupancy unchanged; this is allowed when full and when empty-with-push (pop ignored if empty).
  - fib_valid while full with no pop: the sample is discarded and dropped<=1. Check and counters still update.
  - Latency: a sample pushed into an empty FIFO in cycle N gives out_valid=1, out_data=sample in cycle N+1.
  - Read/write pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. A separate occupancy counter (0..DEPTH) distinguishes full from empty.
- out_data when out_valid=0 holds the last head value; the value is undefined for the consumer.
- No combinational path from fib_valid/fib_in to any output. out_valid and out_data depend only on registers.

Test Plan:
- Basic stream: reset released, out_ready=1; feed 1,1,2,3,5,8 on consecutive fib_valid pulses -> out_data emits 1,1,2,3,5,8 in order, each one cycle after its sample; term_count=6, err=0, err_count=0, wrapped=0.
- Mismatch: feed 1,1,2,4,6 -> err=1 the cycle after 4, err_count=1; 6 matches (4+2), so err_count stays 1; all five terms still output.
- FIFO full/drop (DEPTH=4): out_ready=0, feed 1,1,2,3,5 -> out_valid=1, out_data=1, dropped=1 after the fifth sample. Then raise out_ready -> 1,1,2,3 drain and out_valid returns to 0.
- Full with simultaneous pop: fill 4 entries, then in one cycle fib_valid=1 (value 5) with out_ready=1 -> occupancy stays 4, dropped=0, and 5 is the last term drained.
- Wrap-around: feed 89,144,233,121 (377 mod 256) -> wrapped=1 after 121, err=0; err_count is 0.
- Reset mid-operation: FIFO holding 3 entries, err=1. Pull reset low between clock edges -> out_valid, err, term_count go to 0 immediately, without waiting for a clock. After release, feeding 1,1,2 produces clean output. Repeat the scenario with clear=1 for one cycle -> same result on the next edge.

Source files
------------

// File: rtl/fib_monitor.sv
// rtl/fib_monitor.sv - Fibonacci recurrence checker with term statistics and show-ahead output FIFO
//
// Purpose:
//   Samples each newly loaded term from the Fibonacci sequencer. Every sample
//   from the third one onwards is checked against p1+p2 mod 2^WIDTH. The
//   monitor keeps saturating sample and mismatch counts and sticky error, wrap
//   and drop flags. Samples are buffered in a DEPTH-entry show-ahead FIFO and
//   handed to a consumer over a valid/ready handshake.
//
// Ports:
//   clock      - single clock, all state updates on posedge
//   reset      - asynchronous active-low reset
//   fib_in     - term from the sequencer output
//   fib_valid  - fib_in holds a newly loaded term this cycle
//   clear      - synchronous clear; same effect as reset; has priority
//   out_data   - FIFO head term (holds the last head value while empty)
//   out_valid  - FIFO not empty
//   out_ready  - consumer accepts out_data this cycle
//   term_count - terms sampled, saturating
//   err_count  - recurrence mismatches, saturating
//   err        - sticky: at least one mismatch
//   wrapped    - sticky: a checked term's true sum exceeded 2^WIDTH-1
//   dropped    - sticky: a term was lost to a full FIFO

module fib_monitor #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] fib_in,
  input  logic             fib_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] term_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err,
  output logic             wrapped,
  output logic             dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [WIDTH-1:0] last_head_q, last_head_d;

  logic [WIDTH-1:0] p1_q, p1_d;
  logic [WIDTH-1:0] p2_q, p2_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             wrapped_q, wrapped_d;
  logic             dropped_q, dropped_d;

  // ---------------------------------------------------------------------------
  // Datapath decisions
  // ---------------------------------------------------------------------------
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_pop;
  logic             fifo_push;
  logic             fifo_drop;
  logic [WIDTH:0]   sum_full;
  logic             check_en;
  logic             mismatch;
  logic             carry;

  always_comb begin
    fifo_empty = (occ_q == '0);
    fifo_full  = (occ_q == OCC_FULL);
    // A pop can only happen while something is held, so a push into an empty
    // FIFO never pairs with a pop.
    fifo_pop   = !fifo_empty && out_ready;
    // When full, a same-cycle pop frees the slot the new sample lands in.
    fifo_push  = fib_valid && (!fifo_full || fifo_pop);
    fifo_drop  = fib_valid && fifo_full && !fifo_pop;

    sum_full   = {1'b0, p1_q} + {1'b0, p2_q};
    // The first two samples only seed the history.
    check_en   = fib_valid && (term_cnt_q >= CNT_TWO);
    mismatch   = check_en && (fib_in != sum_full[WIDTH-1:0]);
    carry      = check_en && sum_full[WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    last_head_d = last_head_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    term_cnt_d  = term_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_d       = err_q;
    wrapped_d   = wrapped_q;
    dropped_d   = dropped_q;

    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = '0;
      end
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      last_head_d = '0;
      p1_d        = '0;
      p2_d        = '0;
      term_cnt_d  = '0;
      err_cnt_d   = '0;
      err_d       = 1'b0;
      wrapped_d   = 1'b0;
      dropped_d   = 1'b0;
    end else begin
      // Sampling and recurrence statistics run regardless of FIFO state.
      if (fib_valid) begin
        p2_d = p1_q;
        p1_d = fib_in;
        if (term_cnt_q != CNT_MAX) begin
          term_cnt_d = term_cnt_q + CNT_ONE;
        end
      end

      if (mismatch) begin
        err_d = 1'b1;
        if (err_cnt_q != CNT_MAX) begin
          err_cnt_d = err_cnt_q + CNT_ONE;
        end
      end

      if (carry) begin
        wrapped_d = 1'b1;
      end

      if (fifo_drop) begin
        dropped_d = 1'b1;
      end

      // FIFO
      if (fifo_push) begin
        mem_d[wr_ptr_q] = fib_in;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end

      if (fifo_pop) begin
        // Remember the departing head so out_data holds it once empty.
        last_head_d = mem_q[rd_ptr_q];
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end

      case ({fifo_push, fifo_pop})
        2'b10:   occ_d = occ_q + OCC_ONE;
        2'b01:   occ_d = occ_q - OCC_ONE;
        default: occ_d = occ_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      last_head_q <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      term_cnt_q  <= '0;
      err_cnt_q   <= '0;
      err_q       <= 1'b0;
      wrapped_q   <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      last_head_q <= last_head_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      term_cnt_q  <= term_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_q       <= err_d;
      wrapped_q   <= wrapped_d;
      dropped_q   <= dropped_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all derived from registers only
  // ---------------------------------------------------------------------------
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_empty ? last_head_q : mem_q[rd_ptr_q];
  assign term_count = term_cnt_q;
  assign err_count  = err_cnt_q;
  assign err        = err_q;
  assign wrapped    = wrapped_q;
  assign dropped    = dropped_q;

endmodule

// File: tb/tb_fib_monitor.sv
// tb/tb_fib_monitor.sv - scoreboard testbench for fib_monitor
module tb_fib_monitor;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] fib_in = '0;
  logic             fib_valid = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] term_count;
  logic [CNT_W-1:0] err_count;
  logic             err;
  logic             wrapped;
  logic             dropped;

  fib_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .fib_in     (fib_in),
    .fib_valid  (fib_valid),
    .clear      (clear),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .term_count (term_count),
    .err_count  (err_count),
    .err        (err),
    .wrapped    (wrapped),
    .dropped    (dropped)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] expq [$];
  logic [WIDTH-1:0] mon_exp;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at the negedge is the pop at the next posedge.
  always @(negedge clock) begin
    if (reset && !clear && out_valid === 1'b1 && out_ready) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL out_unexpected: got %0d expected no output", out_data);
      end else begin
        mon_exp = expq.pop_front();
        if (out_data !== mon_exp) begin
          bad++;
          $display("FAIL out_data: got %0d expected %0d", out_data, mon_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] v, input bit push);
    fib_valid = 1'b1;
    fib_in    = v;
    if (push) expq.push_back(v);
    step();
    fib_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    expq.delete();
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (expq.size() == 0 && out_valid == 1'b0) break;
      step();
    end
    check({name, "_queue_left"}, expq.size(), 0);
    check({name, "_valid_after"}, out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] basic [6];
    basic[0] = 8'd1; basic[1] = 8'd1; basic[2] = 8'd2;
    basic[3] = 8'd3; basic[4] = 8'd5; basic[5] = 8'd8;

    // Reset state
    #1 reset = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_term_count", term_count, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err", err, 0);
    check("rst_wrapped", wrapped, 0);
    check("rst_dropped", dropped, 0);
    reset = 1'b1;
    step();

    // Basic stream, one-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(basic[i], 1'b1);
      check("basic_latency_valid", out_valid, 1);
      check("basic_latency_data", out_data, basic[i]);
    end
    drain("basic");
    check("basic_term_count", term_count, 6);
    check("basic_err", err, 0);
    check("basic_err_count", err_count, 0);
    check("basic_wrapped", wrapped, 0);

    // Mismatch
    do_clear();
    out_ready = 1'b1;
    send(8'd1, 1'b1);
    send(8'd1, 1'b1);
    send(8'd2, 1'b1);
    check("mis_err_before", err, 0);
    send(8'd4, 1'b1);
    check("mis_err_after4", err, 1);
    check("mis_errcnt_after4", err_count, 1);
    send(8'd6, 1'b1);
    check("mis_errcnt_after6", err_count, 1);
    check("mis_term_count", term_count, 5);
    drain("mis");

    // FIFO full and drop
    do_clear();
    out_ready = 1'b0;
    send(8'd1, 1'b1);
    send(8'd1, 1'b1);
    send(8'd2, 1'b1);
    send(8'd3, 1'b1);
    check("full_dropped_before", dropped, 0);
    send(8'd5, 1'b0);
    check("full_out_valid", out_valid, 1);
    check("full_out_data", out_data, 1);
    check("full_dropped", dropped, 1);
    check("full_term_count", term_count, 5);
    check("full_err", err, 0);
    drain("full");

    // Full with simultaneous pop
    do_clear();
    out_ready = 1'b0;
    send(8'd1, 1'b1);
    send(8'd1, 1'b1);
    send(8'd2, 1'b1);
    send(8'd3, 1'b1);
    out_ready = 1'b1;
    send(8'd5, 1'b1);
    out_ready = 1'b0;
    check("fpop_dropped", dropped, 0);
    check("fpop_head", out_data, 1);
    send(8'd8, 1'b0);  // still full: occupancy was unchanged by push+pop
    check("fpop_full_again", dropped, 1);
    check("fpop_err", err, 0);
    drain("fpop");

    // Wrap-around
    do_clear();
    out_ready = 1'b1;
    send(8'd89, 1'b1);
    send(8'd144, 1'b1);
    send(8'd233, 1'b1);
    check("wrap_before", wrapped, 0);
    send(8'd121, 1'b1);
    check("wrap_flag", wrapped, 1);
    check("wrap_err", err, 0);
    check("wrap_err_count", err_count, 0);
    drain("wrap");

    // Asynchronous reset mid-operation
    do_clear();
    out_ready = 1'b0;
    send(8'd1, 1'b1);
    send(8'd1, 1'b1);
    send(8'd5, 1'b1);
    check("arst_pre_err", err, 1);
    check("arst_pre_valid", out_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_err", err, 0);
    check("arst_term_count", term_count, 0);
    expq.delete();
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    send(8'd1, 1'b1);
    send(8'd1, 1'b1);
    send(8'd2, 1'b1);
    check("arst_post_err", err, 0);
    check("arst_post_term_count", term_count, 3);
    drain("arst");

    // Synchronous clear mid-operation
    out_ready = 1'b0;
    do_clear();
    send(8'd1, 1'b1);
    send(8'd1, 1'b1);
    send(8'd5, 1'b1);
    check("clr_pre_err", err, 1);
    clear = 1'b1;
    #1;
    check("clr_not_yet", out_valid, 1);
    step();
    clear = 1'b0;
    expq.delete();
    check("clr_out_valid", out_valid, 0);
    check("clr_err", err, 0);
    check("clr_err_count", err_count, 0);
    check("clr_term_count", term_count, 0);
    out_ready = 1'b1;
    send(8'd1, 1'b1);
    send(8'd1, 1'b1);
    send(8'd2, 1'b1);
    check("clr_post_err", err, 0);
    check("clr_post_term_count", term_count, 3);
    drain("clr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
